// File: rtl/imem_responder.sv
// Instruction-memory responder: captures mem[pc] at request accept and presents it LATENCY cycles later.
// Single outstanding fetch. req_ready drops while a response is held unaccepted. flush drops any in-flight fetch.
module imem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] ERR_DATA   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [31:0]           mem [DEPTH];
  logic                  accept;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  addr_err;

  // resp_ready feeds req_ready combinationally so LATENCY=1 sustains one fetch per cycle.
  assign req_ready  = !flush && (state == IDLE || (state == RESP && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  assign rd_idx   = req_addr[DEPTH_LOG2+1:2];
  assign rd_word  = mem[rd_idx];
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);

  // Read is sampled from the pre-edge array, so a same-cycle load to that word is not seen.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else if (accept) begin
      if (LATENCY == 1) begin
        state_nxt = RESP;
        cnt_nxt   = 4'd0;
      end else begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_INIT;
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt <= 4'd1) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Result is frozen at accept; the payload may change during WAIT but is stable across RESP.
      if (accept) begin
        resp_data <= addr_err ? ERR_DATA : rd_word;
        resp_err  <= addr_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: LATENCY=2 instance for function/backpressure/flush/reset, LATENCY=1 instance for throughput.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, resp_data;

  logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready, r1_resp_err;
  logic [31:0] r1_req_addr, r1_resp_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .ERR_DATA(32'h00000013)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .ERR_DATA(32'h00000013)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_addr(r1_req_addr),
    .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready), .resp_data(r1_resp_data), .resp_err(r1_resp_err),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven there, outputs checked 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic fetch2(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = 1'b1;
    #3 chk({tag, "_rdy"}, req_ready, 1);
    cyc();
    req_valid = 1'b0;
    #3 chk({tag, "_wait"}, resp_valid, 0);
    cyc();
    #3 chk({tag, "_vld"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp_d);
    chk({tag, "_err"}, resp_err, exp_e);
    cyc();
    #3 chk({tag, "_done"}, resp_valid, 0);
    cyc();
  endtask

  logic [31:0] words [4] = '{32'h00500093, 32'h00A00113, 32'h00F00193, 32'hDEADBEEF};

  initial begin
    rst = 1'b0; flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_req_addr = '0; r1_resp_ready = 1'b0;

    #2;
    chk("rst_vld", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rdy", req_ready, 1);
    cyc();
    rst = 1'b1;
    cyc();

    load(10'd0, 32'h00500093);
    load(10'd1, 32'h00A00113);
    load(10'd2, 32'h00F00193);
    load(10'd3, 32'h11111111);

    // 1. basic fetch
    fetch2("t1a", 32'h0, 32'h00500093, 1'b0);
    fetch2("t1b", 32'h4, 32'h00A00113, 1'b0);

    // 2. backpressure
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #3 chk("t2_vld", resp_valid, 1);
      chk("t2_data", resp_data, 32'h00A00113);
      chk("t2_rdy", req_ready, 0);
      cyc();
    end
    resp_ready = 1'b1;
    #3 chk("t2_hs_rdy", req_ready, 1);
    chk("t2_hs_vld", resp_valid, 1);
    cyc();
    #3 chk("t2_after", resp_valid, 0);
    cyc();

    // 3. errors: misaligned, then out of range (index bits alias word 0)
    fetch2("t3a", 32'h2, 32'h00000013, 1'b1);
    fetch2("t3b", 32'h00001000, 32'h00000013, 1'b1);

    // 4. flush in WAIT with a competing request
    req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    cyc();
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    #3 chk("t4_flush_rdy", req_ready, 0);
    cyc();
    flush = 1'b0;
    #3 chk("t4_no_vld", resp_valid, 0);
    chk("t4_rdy", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    #3 chk("t4_wait", resp_valid, 0);
    cyc();
    #3 chk("t4_vld", resp_valid, 1);
    chk("t4_data", resp_data, 32'h00A00113);
    chk("t4_err", resp_err, 0);
    cyc();
    #3 chk("t4_done", resp_valid, 0);
    cyc();

    // 5. read-before-write on a same-cycle load
    req_valid = 1'b1; req_addr = 32'hC; resp_ready = 1'b1;
    load_en = 1'b1; load_addr = 10'd3; load_data = 32'hDEADBEEF;
    cyc();
    req_valid = 1'b0; load_en = 1'b0;
    cyc();
    #3 chk("t5_vld", resp_valid, 1);
    chk("t5_old", resp_data, 32'h11111111);
    cyc();
    cyc();
    fetch2("t5_new", 32'hC, 32'hDEADBEEF, 1'b0);

    // 5b. async reset mid-WAIT
    req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #2 chk("t5r_vld", resp_valid, 0);
    chk("t5r_rdy", req_ready, 1);
    chk("t5r_data", resp_data, 0);
    chk("t5r_err", resp_err, 0);
    cyc();
    #3 chk("t5r_hold", resp_valid, 0);
    cyc();
    rst = 1'b1;
    #3 chk("t5r_rel", resp_valid, 0);
    cyc();
    #3 chk("t5r_rel2", resp_valid, 0);
    cyc();

    // 6. LATENCY=1 back-to-back
    r1_req_valid = 1'b1; r1_req_addr = 32'h0; r1_resp_ready = 1'b1;
    #3 chk("t6_rdy", r1_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i < 3) r1_req_addr = 32'((i + 1) * 4);
      else r1_req_valid = 1'b0;
      #3 chk("t6_vld", r1_resp_valid, 1);
      chk("t6_data", r1_resp_data, words[i]);
      chk("t6_err", r1_resp_err, 0);
    end
    cyc();
    #3 chk("t6_done", r1_resp_valid, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that serves fetch requests issued by the IF stage.
- Accepts a byte PC and returns the 32-bit instruction word (order_data) after a configurable latency.
- Uses a valid/ready handshake in both directions and supports a flush to drop in-flight fetches on redirect.
- Holds a word-addressed instruction array that the program loader fills through a dedicated write port.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB)
LATENCY, 2, cycles from request accept edge to resp_valid high; legal range 1..15
ERR_DATA, 32'h00000013, word returned on error (RV32I NOP, addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept request this cycle
req_addr  in  32  byte address (PC)
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_data  out  32  instruction word (order_data)
resp_err  out  1  request was misaligned or out of range
flush  in  1  drop in-flight request or response
load_en  in  1  loader write strobe
load_addr  in  DEPTH_LOG2  loader word address
load_data  in  32  loader write data

Behaviour:
- Reset (rst low, async): state=IDLE, resp_valid=0, resp_data=0, resp_err=0, latency counter=0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
- req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)). The combinational path resp_ready->req_ready is intentional so LATENCY=1 gives back-to-back throughput.
- Accept: req_valid && req_ready at a rising edge.
  - At accept, capture word = mem[req_addr[DEPTH_LOG2+1:2]].
  - At accept, capture err = (req_addr[1:0]!=0) || (req_addr[31:DEPTH_LOG2+2]!=0).
  - The captured value is final. Later loader writes do not alter an in-flight response.
- Next state after accept:
  - LATENCY==1: go to RESP.
  - Otherwise: go to WAIT with counter=LATENCY-1. Decrement each cycle in WAIT; enter RESP when counter reaches 1.
  - Result: resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid=1.
  - resp_data = err ? ERR_DATA : word.
  - resp_err = err.
  - All three are held stable until resp_valid && resp_ready.
- Response handshake without a new accept: next state IDLE, resp_valid=0.
- Response handshake with a new accept in the same cycle: the new request is captured and the latency rule applies. For LATENCY=1, resp_valid stays high with new data.
- resp_ready is ignored outside RESP.
- flush (synchronous, highest priority): from any state, next state IDLE and resp_valid=0 on the next edge. A req_valid in the flush cycle is not accepted because req_ready=0. flush in IDLE has no effect.
- Loader:
  - On the rising edge with load_en=1, mem[load_addr] <= load_data. This is independent of state.
  - Same-cycle load and accept to the same word: the request captures the OLD word (read-before-write).
- resp_data and resp_err outside RESP hold their last values and are don't-care to consumers. At reset they are 0.
- Single outstanding request; no queueing.

Test Plan:
1. Basic fetch, LATENCY=2:
   - Stimulus: load mem[0]=32'h00500093 and mem[1]=32'h00A00113; request addr 0x0, then 0x4, with resp_ready=1.
   - Required: resp_data=32'h00500093 two cycles after its accept, then 32'h00A00113 two cycles after its accept; resp_err=0.
2. Backpressure:
   - Stimulus: hold resp_ready=0 for 5 cycles in RESP.
   - Required: resp_valid=1 and resp_data stable throughout; req_ready=0; a single handshake on the cycle resp_ready=1.
3. Errors:
   - Stimulus: request addr 0x2, then addr 0x00001000 (DEPTH_LOG2=10).
   - Required: resp_err=1 and resp_data=32'h00000013 for both.
4. Flush:
   - Stimulus: assert flush one cycle after accept (in WAIT), together with req_valid=1.
   - Required: no resp_valid for the flushed request; req_ready=0 in the flush cycle; a new request the following cycle completes normally.
5. Read-before-write and async reset:
   - Stimulus: load mem[3]=32'hDEADBEEF in the same cycle as an accept at addr 0xC, where mem[3] was previously 32'h11111111.
   - Required: response is 32'h11111111.
   - Stimulus: then drive rst low mid-WAIT, between clock edges.
   - Required: resp_valid=0 and state IDLE immediately, not waiting for a clock edge.
6. Throughput, LATENCY=1:
   - Stimulus: req_valid and resp_ready held at 1 over 4 sequential addresses.
   - Required: resp_valid high on 4 consecutive cycles with the correct words in order.
